// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// BOOT/RUN/HALT controller. Instruction memory is combinational and outside
// this block; it answers instr_addr with instruction_in in the same cycle.
//
// Control contract: stall and flush are level inputs sampled on each rising
// clk edge. stall=1 holds the PC and IF/ID. flush=1 replaces the IF/ID
// contents with a bubble on that edge. branch_taken=1 redirects the PC on that
// edge and also writes a bubble. The order of precedence is misaligned
// redirect, then branch, then flush, then stall, then normal advance.
// Nothing is accepted in BOOT or HALT.
module if_stage #(
  parameter logic [63:0] RESET_PC  = 64'd40,
  parameter logic [63:0] LAST_PC   = 64'd84,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic [31:0] instruction_in,
  output logic [63:0] instr_addr,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [63:0] r_pc;
  logic [63:0] r_if_id_pc;
  logic [31:0] r_if_id_instr;
  logic        r_if_id_valid;
  logic        r_misalign_err;

  logic [63:0] w_pc_nxt;
  logic [63:0] w_if_id_pc_nxt;
  logic [31:0] w_if_id_instr_nxt;
  logic        w_if_id_valid_nxt;
  logic        w_misalign_err_nxt;

  logic [63:0] w_pc_plus4;
  logic        w_misalign_redirect;
  logic        w_target_past_end;
  logic        w_advance_past_end;

  // PC+4 wraps modulo 2^64; only the LAST_PC comparison can stop fetching.
  assign w_pc_plus4          = r_pc + 64'd4;
  assign w_misalign_redirect = branch_taken && (branch_target[1:0] != 2'b00);
  assign w_target_past_end   = branch_target > LAST_PC;
  assign w_advance_past_end  = w_pc_plus4 > LAST_PC;

  // State register: reset always restarts in BOOT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: BOOT lasts one cycle, HALT is left only by reset.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_misalign_redirect) begin
          w_state_nxt = ST_HALT;
        end else if (branch_taken) begin
          w_state_nxt = w_target_past_end ? ST_HALT : ST_RUN;
        end else if (stall) begin
          // Stalled (with or without flush): PC holds, so no end-of-program check.
          w_state_nxt = ST_RUN;
        end else if (w_advance_past_end) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Output/datapath logic: next PC, next IF/ID contents and the sticky error.
  always_comb begin
    w_pc_nxt           = r_pc;
    w_if_id_pc_nxt     = r_if_id_pc;
    w_if_id_instr_nxt  = r_if_id_instr;
    w_if_id_valid_nxt  = r_if_id_valid;
    w_misalign_err_nxt = r_misalign_err;
    unique case (r_state)
      ST_BOOT: begin
        // Inputs ignored; the first fetch address is presented for one cycle.
        w_if_id_valid_nxt = 1'b0;
      end
      ST_RUN: begin
        if (w_misalign_redirect) begin
          // Bad redirect: keep the PC, drop IF/ID and record the error.
          w_misalign_err_nxt = 1'b1;
          w_if_id_pc_nxt     = r_pc;
          w_if_id_instr_nxt  = NOP_INSTR;
          w_if_id_valid_nxt  = 1'b0;
        end else if (branch_taken) begin
          // Redirect wins over stall; the wrong-path fetch becomes a bubble.
          w_pc_nxt          = branch_target;
          w_if_id_pc_nxt    = r_pc;
          w_if_id_instr_nxt = NOP_INSTR;
          w_if_id_valid_nxt = 1'b0;
        end else if (flush) begin
          // Flush squashes IF/ID; the PC still obeys stall.
          w_if_id_pc_nxt    = r_pc;
          w_if_id_instr_nxt = NOP_INSTR;
          w_if_id_valid_nxt = 1'b0;
          if (!stall) begin
            w_pc_nxt = w_pc_plus4;
          end
        end else if (!stall) begin
          // Normal advance: capture this fetch, move to the next word.
          w_pc_nxt          = w_pc_plus4;
          w_if_id_pc_nxt    = r_pc;
          w_if_id_instr_nxt = instruction_in;
          w_if_id_valid_nxt = 1'b1;
        end
      end
      ST_HALT: begin
        // Everything frozen except that IF/ID no longer presents a real op.
        w_if_id_valid_nxt = 1'b0;
      end
      default: begin
        w_if_id_valid_nxt = 1'b0;
      end
    endcase
  end

  // PC, IF/ID and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc           <= RESET_PC;
      r_if_id_pc     <= 64'd0;
      r_if_id_instr  <= NOP_INSTR;
      r_if_id_valid  <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      r_pc           <= w_pc_nxt;
      r_if_id_pc     <= w_if_id_pc_nxt;
      r_if_id_instr  <= w_if_id_instr_nxt;
      r_if_id_valid  <= w_if_id_valid_nxt;
      r_misalign_err <= w_misalign_err_nxt;
    end
  end

  assign instr_addr   = r_pc;
  assign if_id_pc     = r_if_id_pc;
  assign if_id_instr  = r_if_id_instr;
  assign if_id_valid  = r_if_id_valid;
  assign halted       = (r_state == ST_HALT);
  assign misalign_err = r_misalign_err;
  assign dbg_state    = r_state;

endmodule
